// File: rtl/fpu_add_scheduler.sv
// fpu_add_scheduler: round-robin scheduler sharing one combinational FP adder.
// Ports: req_valid/req_sub/req_a/req_b in, one-hot req_ready out; add_a/add_b
// drive the external adder and add_sum is its result; res_valid/res_sum/res_id
// form the tagged result port, back-pressured by res_ready; busy flags non-IDLE.
module fpu_add_scheduler #(
    parameter int N_REQ         = 4,
    parameter int ID_W          = 2,
    parameter int total_size    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_sub,
    input  logic [N_REQ*total_size-1:0] req_a,
    input  logic [N_REQ*total_size-1:0] req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic [total_size-1:0]       add_a,
    output logic [total_size-1:0]       add_b,
    input  logic [total_size-1:0]       add_sum,
    output logic                        res_valid,
    output logic [total_size-1:0]       res_sum,
    output logic [ID_W-1:0]             res_id,
    input  logic                        res_ready,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [total_size-1:0] add_a_q, add_a_d;
    logic [total_size-1:0] add_b_q, add_b_d;
    logic [total_size-1:0] res_sum_q, res_sum_d;
    logic                  res_valid_q, res_valid_d;
    logic                  busy_q;

    logic                  found;
    logic [ID_W-1:0]       gnt_id;
    logic [total_size-1:0] sel_a, sel_b;
    logic                  sel_sub;

    // Requesters above the last winner are searched first, then the
    // search wraps to 0..ptr, so the last winner ends up last in line.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && i > int'(ptr_q)) begin
                found  = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && i <= int'(ptr_q)) begin
                found  = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a        = req_a[i*total_size +: total_size];
                sel_b        = req_b[i*total_size +: total_size];
                sel_sub      = req_sub[i];
                req_ready[i] = found && (state_q == IDLE);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    add_a_d = sel_a;
                    // Subtraction is addition with B's sign flipped.
                    add_b_d = {sel_b[total_size-1] ^ sel_sub,
                               sel_b[total_size-2:0]};
                    id_d    = gnt_id;
                    ptr_d   = gnt_id;
                    cnt_d   = 4'(SETTLE_CYCLES - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_sum_d   = add_sum;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// tb_fpu_add_scheduler: directed + randomized bench for fpu_add_scheduler.
// Two instances: settle window 1 (main checks) and settle window 4.
module tb_fpu_add_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 1: SETTLE_CYCLES = 1
    logic [3:0]   rv1 = '0, rs1 = '0, rr1;
    logic [127:0] ra1 = '0, rb1 = '0;
    logic [31:0]  aa1, ab1, as1, ress1;
    logic         resv1, resr1 = 1'b1, busy1;
    logic [1:0]   resid1;

    // instance 2: SETTLE_CYCLES = 4
    logic [3:0]   rv2 = '0, rs2 = '0, rr2;
    logic [127:0] ra2 = '0, rb2 = '0;
    logic [31:0]  aa2, ab2, ress2;
    logic [31:0]  p1 = '0, p2 = '0, as2 = '0;
    logic         resv2, resr2 = 1'b1, busy2;
    logic [1:0]   resid2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] a1 [4];
    logic [31:0] b1 [4];
    logic [3:0]  sub1;
    int          last1 = 3;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(x) + f2r(y));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    // round robin as stated: first valid after the last winner, wrapping
    function automatic int pick(input logic [3:0] m, input int last);
        for (int j = 1; j <= 4; j++)
            if (m[(last + j) % 4]) return (last + j) % 4;
        return -1;
    endfunction

    // model adders: instance 1 combinational, instance 2 with 3-cycle lag
    assign as1 = fadd(aa1, ab1);
    always @(posedge clk) begin
        p1  <= fadd(aa2, ab2);
        p2  <= p1;
        as2 <= p2;
    end

    fpu_add_scheduler #(.N_REQ(4), .ID_W(2), .total_size(32), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_sub(rs1),
        .req_a(ra1), .req_b(rb1), .req_ready(rr1), .add_a(aa1), .add_b(ab1),
        .add_sum(as1), .res_valid(resv1), .res_sum(ress1), .res_id(resid1),
        .res_ready(resr1), .busy(busy1));

    fpu_add_scheduler #(.N_REQ(4), .ID_W(2), .total_size(32), .SETTLE_CYCLES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_sub(rs2),
        .req_a(ra2), .req_b(rb2), .req_ready(rr2), .add_a(aa2), .add_b(ab2),
        .add_sum(as2), .res_valid(resv2), .res_sum(ress2), .res_id(resid2),
        .res_ready(resr2), .busy(busy2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load1();
        for (int i = 0; i < 4; i++) begin
            ra1[i*32 +: 32] = a1[i];
            rb1[i*32 +: 32] = b1[i];
        end
        rs1 = sub1;
    endtask

    // one transaction on instance 1; called at a negedge with the DUT idle
    task automatic do_op1(input logic [3:0] mask, input int hold, input bit rnd);
        int          g, cyc;
        logic [31:0] eb, es, s0;
        logic [1:0]  i0;
        if (rnd) begin
            for (int i = 0; i < 4; i++) begin
                a1[i] = rnd_f();
                b1[i] = rnd_f();
            end
            sub1 = 4'($urandom);
        end
        load1();
        rv1   = mask;
        resr1 = (hold == 0);
        #1;
        g = pick(mask, last1);
        chk("grant", rr1, 64'(1 << g));
        @(negedge clk);
        last1 = g;
        eb = b1[g] ^ {sub1[g], 31'd0};
        es = fadd(a1[g], eb);
        chk("add_a", aa1, a1[g]);
        chk("add_b", ab1, eb);
        chk("busy_exec", busy1, 1);
        chk("ready_exec", rr1, 0);
        cyc = 0;
        while (resv1 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("res_latency", cyc, 1);
        chk("res_sum", ress1, es);
        chk("res_id", resid1, g);
        s0 = ress1;
        i0 = resid1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", resv1, 1);
            chk("bp_sum", ress1, s0);
            chk("bp_id", resid1, i0);
            chk("bp_ready", rr1, 0);
        end
        resr1 = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy1, 0);
        chk("idle_valid", resv1, 0);
    endtask

    // one transaction on instance 2 (requester 0), checks the settle window
    task automatic do_op2(input logic [31:0] a, input logic [31:0] b, input logic s);
        int          first, nb;
        logic [31:0] got, eb;
        eb = b ^ {s, 31'd0};
        ra2[31:0] = a;
        rb2[31:0] = b;
        rs2 = {3'd0, s};
        rv2 = 4'b0001;
        #1;
        chk("s4_grant", rr2, 4'b0001);
        @(negedge clk);
        rv2 = '0;
        chk("s4_add_b", ab2, eb);
        first = -1;
        nb = 0;
        got = '0;
        for (int t = 0; t < 8; t++) begin
            if (busy2 === 1'b1) nb++;
            if (resv2 === 1'b1 && first < 0) begin
                first = t;
                got = ress2;
            end
            @(negedge clk);
        end
        chk("s4_latency", first, 4);
        chk("s4_sum", got, fadd(a, eb));
        chk("s4_busy_len", nb, 5);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a1[i] = '0;
            b1[i] = '0;
        end
        sub1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", rr1, 0);
        chk("rst_add_a", aa1, 0);
        chk("rst_add_b", ab1, 0);
        chk("rst_res_valid", resv1, 0);
        chk("rst_res_sum", ress1, 0);
        chk("rst_res_id", resid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst2_busy", busy2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single add from requester 2
        a1[2] = 32'h3F800000;
        b1[2] = 32'h40000000;
        sub1  = 4'b0000;
        do_op1(4'b0100, 0, 1'b0);
        chk("add_b_held", ab1, 32'h40000000);
        rv1 = '0;

        // subtract from requester 0
        a1[0] = 32'h40400000;
        b1[0] = 32'h3F800000;
        sub1  = 4'b0001;
        do_op1(4'b0001, 0, 1'b0);
        chk("sub_add_b", ab1, 32'hBF800000);
        rv1 = '0;

        // back-pressure while requester 2 also waits
        do_op1(4'b0110, 5, 1'b1);
        chk("bp_regrant", rr1, 4'b0100);
        rv1 = '0;

        // reset during EXEC
        for (int i = 0; i < 4; i++) begin
            a1[i] = rnd_f();
            b1[i] = rnd_f();
        end
        load1();
        rv1 = 4'b1000;
        #1;
        chk("pre_rst_grant", rr1, 4'b1000);
        @(negedge clk);
        chk("pre_rst_busy", busy1, 1);
        rst_n = 1'b0;
        rv1 = '0;
        #1;
        chk("arst_add_a", aa1, 0);
        chk("arst_add_b", ab1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_valid", resv1, 0);
        chk("arst_ready", rr1, 0);
        repeat (2) @(negedge clk);
        chk("arst_no_res", resv1, 0);
        rst_n = 1'b1;
        last1 = 3;

        // fairness: all held high, rotation starts at 0 again
        for (int k = 0; k < 5; k++) do_op1(4'b1111, 0, 1'b1);

        // randomized masks and back-pressure
        for (int k = 0; k < 12; k++)
            do_op1(4'($urandom_range(15, 1)), $urandom_range(3, 0), 1'b1);
        rv1 = '0;

        // settle window on instance 2
        do_op2(32'h3F800000, 32'h40000000, 1'b0);
        do_op2(32'h40A00000, 32'h3F800000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_add_scheduler.md
# fpu_add_scheduler

Round-robin scheduler that shares one combinational 32-bit floating-point adder between `N_REQ` requesters. It accepts one operation at a time through a valid/ready handshake. It optionally turns subtraction into addition by flipping the sign of operand B, then holds the operands stable on the adder inputs for a programmable settle window. It captures the sum and returns it, tagged with the requester ID, through a back-pressured result port. The adder is instantiated beside this block; the scheduler only drives its operands and samples its sum.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester ID width; 2**`ID_W` >= `N_REQ`.
- `total_size`, 32: FP word width; sign is bit `total_size`-1.
- `SETTLE_CYCLES`, 1: cycles operands are held before the sum is sampled (1..15).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `N_REQ`  request pending, one bit per requester.
- `req_sub`  in  `N_REQ`  per-requester op select: 1 = A-B, 0 = A+B.
- `req_a`  in  `N_REQ`*`total_size`  operand A, requester i at slice [i*`total_size` +: `total_size`].
- `req_b`  in  `N_REQ`*`total_size`  operand B, same packing.
- `req_ready`  out  `N_REQ`  one-hot accept; at most one bit high.
- `add_a`  out  `total_size`  adder operand A (registered).
- `add_b`  out  `total_size`  adder operand B (registered, sign already adjusted).
- `add_sum`  in  `total_size`  adder result.
- `res_valid`  out  1  result available.
- `res_sum`  out  `total_size`  captured sum.
- `res_id`  out  `ID_W`  requester index of `res_sum`.
- `res_ready`  in  1  consumer accepts result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE**
  - Round-robin arbitration. Search order starts at `ptr`+1 and wraps modulo `N_REQ`.
  - The first requester i with `req_valid[i]` gets `req_ready[i]`=1. This is combinational from `req_valid` and `ptr`.
  - On the accept edge:
    - `add_a` <= A of requester i.
    - `add_b` <= B of requester i, with bit `total_size`-1 inverted if `req_sub[i]`.
    - `id_q` <= i, `ptr` <= i, `cnt` <= `SETTLE_CYCLES`-1.
    - State <= EXEC.
- **EXEC**
  - `req_ready` is all zero.
  - `add_a` and `add_b` stay stable.
  - If `cnt` != 0: `cnt` decrements.
  - If `cnt` == 0: `res_sum` <= `add_sum`, `res_id` <= `id_q`, `res_valid` <= 1, state <= DONE.
- **DONE**
  - `res_valid`=1; `res_sum` and `res_id` are held.
  - On `res_valid`&`res_ready`: `res_valid` <= 0 and state <= IDLE.
  - No new request is accepted in the same cycle.
- `add_a` and `add_b` keep their last values after the operation. They change only on an accept.
- Requesters must hold `req_valid` and their operands until they see `req_ready`. Dropping `req_valid` earlier simply removes the request.
- A requester that keeps `req_valid` high after being served gets lowest priority on the next arbitration.
- Simultaneous requests from all requesters are served in rotation. No requester waits more than `N_REQ`-1 grants.
- Reset values:
  - state IDLE; `ptr`=`N_REQ`-1, so requester 0 has top priority after reset.
  - `cnt`=0, `id_q`=0.
  - `add_a`=`add_b`=0, `res_sum`=0, `res_id`=0, `res_valid`=0, `busy`=0, `req_ready`=0 (no valid requests).
- Reset asserted mid-operation aborts it with no result. The interrupted requester is not acknowledged a second time.

## Timing
- Accept at edge k puts operands on `add_a`/`add_b` from k.
- `add_sum` is sampled at edge k+`SETTLE_CYCLES`.
- `res_valid` goes high after edge k+`SETTLE_CYCLES`.
- Minimum issue interval is `SETTLE_CYCLES`+2 cycles, with `res_ready` held high.
- `req_ready` may be high only while state is IDLE.
- `busy` is registered and equals (state != IDLE).

## Test plan
- **Single add, `SETTLE_CYCLES`=1:** requester 2 sends A=0x3F800000, B=0x40000000, sub=0, model adder returns the true sum. Expect `req_ready`=0b0100, `add_b`=0x40000000, `res_valid` one cycle after the accept, `res_sum`=0x40400000, `res_id`=2.
- **Subtract:** requester 0 sends A=0x40400000, B=0x3F800000, sub=1. Expect `add_b`=0xBF800000 and `res_sum`=0x40000000.
- **Fairness:** all four `req_valid` held high. Grants come in order 0,1,2,3,0, with `res_id` following the same sequence.
- **Back-pressure:** `res_ready`=0 for 5 cycles after `res_valid`. Expect `res_sum`/`res_id` stable, `req_ready`=0 throughout, and a return to IDLE one cycle after `res_ready`=1.
- **Settle window:** `SETTLE_CYCLES`=4; the model adder changes `add_sum` only 3 cycles after the operands change. Expect the sample at accept+4 and `busy` high for exactly 5 cycles when `res_ready`=1.
- **Reset mid-EXEC:** `rst_n` dropped one cycle after accept. Expect all outputs at their reset values immediately (asynchronous), no `res_valid`, and requester 0 granted first after release.
